// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives the program ROM address, registers each
// fetched word into a valid/ready output stage, handles redirects and halt words.
module fetch_unit #(
    parameter int          START_ADDR    = 0,
    parameter int          ROM_DEPTH     = 16,
    parameter logic [15:0] HALT_OPERATOR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_operator,
    input  logic [15:0] rom_operand,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_operator,
    output logic [15:0] instr_operand,
    output logic [15:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
    output logic        busy,
    output logic        halted
);

    // PC is carried 16 bits wide with every bit above the ROM index held at zero,
    // so masking gives both the modulo-ROM_DEPTH wrap and the zero extension.
    localparam logic [15:0] ADDR_MASK = 16'(ROM_DEPTH - 1);
    localparam logic [15:0] START_PC  = 16'(START_ADDR) & ADDR_MASK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic        valid_reg, valid_next;
    logic [15:0] operator_reg, operator_next;
    logic [15:0] operand_reg, operand_next;
    logic [15:0] ipc_reg, ipc_next;
    logic        load;

    assign load = !valid_reg || instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pc_reg       <= START_PC;
            valid_reg    <= 1'b0;
            operator_reg <= 16'h0000;
            operand_reg  <= 16'h0000;
            ipc_reg      <= 16'h0000;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            valid_reg    <= valid_next;
            operator_reg <= operator_next;
            operand_reg  <= operand_next;
            ipc_reg      <= ipc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        valid_next    = valid_reg;
        operator_next = operator_reg;
        operand_next  = operand_reg;
        ipc_next      = ipc_reg;
        case (state_reg)
            IDLE, HALT: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = START_PC;
                    valid_next = 1'b0;
                end
            end
            RUN: begin
                // Redirect wins over any load; a held word is simply discarded.
                if (redirect_valid) begin
                    pc_next    = redirect_addr & ADDR_MASK;
                    valid_next = 1'b0;
                end else if (load) begin
                    if (rom_operator == HALT_OPERATOR) begin
                        state_next = HALT;
                        valid_next = 1'b0;
                    end else begin
                        operator_next = rom_operator;
                        operand_next  = rom_operand;
                        ipc_next      = pc_reg;
                        valid_next    = 1'b1;
                        pc_next       = (pc_reg + 16'd1) & ADDR_MASK;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rom_addr       = pc_reg;
    assign instr_valid    = valid_reg;
    assign instr_operator = operator_reg;
    assign instr_operand  = operand_reg;
    assign instr_pc       = ipc_reg;
    assign busy           = (state_reg == RUN);
    assign halted         = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational 16-word ROM model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] rom_addr;
    logic [15:0] rom_operator;
    logic [15:0] rom_operand;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_operator;
    logic [15:0] instr_operand;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        busy;
    logic        halted;

    logic [31:0] rom [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_operator = rom[rom_addr[3:0]][31:16];
    assign rom_operand  = rom[rom_addr[3:0]][15:0];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .rom_addr       (rom_addr),
        .rom_operator   (rom_operator),
        .rom_operand    (rom_operand),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_operator (instr_operator),
        .instr_operand  (instr_operand),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .busy           (busy),
        .halted         (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input string tag, input int pc);
        logic [15:0] p;
        p = 16'(pc);
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".pc"}, 32'(instr_pc), 32'(p));
        check({tag, ".op"}, 32'(instr_operator), 32'(16'h0100 + p));
        check({tag, ".opnd"}, 32'(instr_operand), 32'(16'h1000 + p));
        $display("instr %s pc=%0d op=%h opnd=%h", tag, instr_pc, instr_operator, instr_operand);
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".valid"}, 32'(instr_valid), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".halted"}, 32'(halted), 32'd0);
        check({tag, ".rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, ".pc"}, 32'(instr_pc), 32'd0);
        check({tag, ".op"}, 32'(instr_operator), 32'd0);
        check({tag, ".opnd"}, 32'(instr_operand), 32'd0);
        $display("reset %s valid=%0d busy=%0d halted=%0d rom_addr=%0d", tag, instr_valid, busy, halted, rom_addr);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = {16'h0100 + 16'(i), 16'h1000 + 16'(i)};
        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_addr = 16'h0000;
        tick(); tick();
        expect_reset("reset");
        rst_n = 1'b1;

        // Redirect while idle must be ignored
        redirect_valid = 1'b1; redirect_addr = 16'd5;
        tick();
        redirect_valid = 1'b0;
        check("idle_redirect.rom_addr", 32'(rom_addr), 32'd0);
        check("idle_redirect.busy", 32'(busy), 32'd0);
        check("idle_redirect.valid", 32'(instr_valid), 32'd0);

        // Start: RUN after E0, first word valid after E1
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start.busy", 32'(busy), 32'd1);
        check("start.valid", 32'(instr_valid), 32'd0);
        check("start.rom_addr", 32'(rom_addr), 32'd0);

        for (int i = 0; i < 18; i++) begin
            tick();
            expect_instr("seq", i % 16);
        end

        // Backpressure while pc 2 is held
        tick();
        expect_instr("bp_load", 2);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_instr("bp_hold", 2);
            check("bp_hold.rom_addr", 32'(rom_addr), 32'd3);
        end
        instr_ready = 1'b1;
        tick();
        expect_instr("bp_release", 3);
        tick();
        expect_instr("bp_next", 4);

        // Redirect to 9 while pc 4 held and not accepted
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 16'd9;
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        check("redir.valid", 32'(instr_valid), 32'd0);
        check("redir.rom_addr", 32'(rom_addr), 32'd9);
        tick();
        expect_instr("redir_target", 9);

        // Redirect with accept in the same cycle; 0x0013 wraps to 3
        redirect_valid = 1'b1; redirect_addr = 16'h0013;
        tick();
        redirect_valid = 1'b0;
        check("redir_wrap.valid", 32'(instr_valid), 32'd0);
        check("redir_wrap.rom_addr", 32'(rom_addr), 32'd3);
        tick();
        expect_instr("redir_wrap_target", 3);
        tick();
        expect_instr("redir_wrap_next", 4);

        // Start while running must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_instr("run_start", 5);
        check("run_start.rom_addr", 32'(rom_addr), 32'd6);
        tick();
        expect_instr("pre_reset", 6);
        tick();
        expect_instr("pre_reset", 7);

        // Reset mid-run
        rst_n = 1'b0;
        tick();
        expect_reset("mid_reset");
        rst_n = 1'b1;

        // Halt word at address 5
        rom[5] = {16'hFFFF, 16'h1005};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_instr("pre_halt", i);
        end
        tick();
        check("halt.halted", 32'(halted), 32'd1);
        check("halt.busy", 32'(busy), 32'd0);
        check("halt.valid", 32'(instr_valid), 32'd0);
        check("halt.rom_addr", 32'(rom_addr), 32'd5);
        $display("halt halted=%0d busy=%0d rom_addr=%0d", halted, busy, rom_addr);
        redirect_valid = 1'b1; redirect_addr = 16'd2;
        tick();
        redirect_valid = 1'b0;
        check("halt_redirect.rom_addr", 32'(rom_addr), 32'd5);
        check("halt_redirect.halted", 32'(halted), 32'd1);
        check("halt_redirect.valid", 32'(instr_valid), 32'd0);

        // Restart from START_ADDR after halt
        rom[5] = {16'h0105, 16'h1005};
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart.busy", 32'(busy), 32'd1);
        check("restart.halted", 32'(halted), 32'd0);
        check("restart.rom_addr", 32'(rom_addr), 32'd0);
        tick();
        expect_instr("restart", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
